// File: rtl/mopshub_uplink_pkg.sv
// Shared types and constants for the MOPSHUB uplink collector.
package mopshub_uplink_pkg;

    localparam int BUS_ID_W = 5;
    localparam int FRAME_W  = 76;

    // state    | meaning
    // IDLE     | waiting for an enabled request with FIFO space
    // SELECT   | bus mux just switched; arm the read-latency timer
    // WAIT     | timer running down while can_rec_data settles
    // CAPTURE  | frame written to FIFO, ack pulsed to the bus
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    typedef struct packed {
        logic [BUS_ID_W-1:0] bus_id;
        logic [FRAME_W-1:0]  frame;
    } uplink_entry_t;

endpackage

// File: rtl/mopshub_uplink_collector_fifo.sv
// Synchronous first-word-fall-through FIFO; head holds the last popped word when empty.
module uplink_sync_fifo #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] hold;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count != (AW+1)'(DEPTH));
    assign pop_ok  = pop && (count != '0);

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy counter and the held last-popped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : hold;
    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;

endmodule

// File: rtl/mopshub_uplink_collector.sv
// Round-robin collector of CAN receive frames into the uplink FIFO.
module mopshub_uplink_collector
    import mopshub_uplink_pkg::*;
#(
    parameter int N_BUSES    = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [N_BUSES-1:0]            irq_can_rec,
    input  logic [FRAME_W-1:0]            can_rec_data,
    output logic [BUS_ID_W-1:0]           can_rec_select,
    output logic                          can_rec_ack,
    output logic [FRAME_W-1:0]            data_rec_uplink,
    output logic [BUS_ID_W-1:0]           uplink_bus_id,
    output logic                          uplink_valid,
    input  logic                          uplink_ready,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int IDX_W = $clog2(N_BUSES);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_t              state;
    logic [BUS_ID_W-1:0] last_served;
    logic [CNT_W-1:0]    wait_cnt;
    uplink_entry_t       wr_entry;
    uplink_entry_t       rd_entry;

    // First set request strictly after 'last', wrapping; last itself is checked last.
    function automatic logic [BUS_ID_W-1:0] rr_pick(
        input logic [N_BUSES-1:0]  req,
        input logic [BUS_ID_W-1:0] last
    );
        logic [BUS_ID_W-1:0] win;
        logic                found;
        int                  idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_BUSES; i++) begin
            idx = (int'(last) + i) % N_BUSES;
            if (!found && req[IDX_W'(idx)]) begin
                win   = BUS_ID_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Grant / settle / capture sequencer with registered select, ack and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            can_rec_select <= '0;
            can_rec_ack    <= 1'b0;
            busy           <= 1'b0;
            last_served    <= BUS_ID_W'(N_BUSES - 1);
            wait_cnt       <= '0;
        end else begin
            can_rec_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (irq_can_rec != '0) && !fifo_full) begin
                        can_rec_select <= rr_pick(irq_can_rec, last_served);
                        state          <= SELECT;
                        busy           <= 1'b1;
                    end
                end
                SELECT: begin
                    wait_cnt <= CNT_W'(RD_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= CAPTURE;
                        can_rec_ack <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    last_served <= can_rec_select;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_entry = '{bus_id: can_rec_select, frame: can_rec_data};

    uplink_sync_fifo #(
        .WIDTH ($bits(uplink_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (state == CAPTURE),
        .wr_data (wr_entry),
        .pop     (uplink_ready),
        .rd_data (rd_entry),
        .valid   (uplink_valid),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    assign data_rec_uplink = rd_entry.frame;
    assign uplink_bus_id   = rd_entry.bus_id;

endmodule

// File: tb/tb_mopshub_uplink_collector.sv
// Bench for the uplink collector: queue-based reference model plus directed scenarios.
module tb_mopshub_uplink_collector;
    localparam int N_BUSES = 32;
    localparam int RD_LAT  = 2;
    localparam int DEPTH   = 8;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] irq;
    logic [75:0] can_rec_data;
    logic [4:0]  can_rec_select;
    logic        can_rec_ack;
    logic [75:0] data_rec_uplink;
    logic [4:0]  uplink_bus_id;
    logic        uplink_valid;
    logic        uplink_ready;
    logic        fifo_full;
    logic [3:0]  fifo_level;
    logic        busy;

    mopshub_uplink_collector #(
        .N_BUSES    (N_BUSES),
        .FIFO_DEPTH (DEPTH),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .irq_can_rec     (irq),
        .can_rec_data    (can_rec_data),
        .can_rec_select  (can_rec_select),
        .can_rec_ack     (can_rec_ack),
        .data_rec_uplink (data_rec_uplink),
        .uplink_bus_id   (uplink_bus_id),
        .uplink_valid    (uplink_valid),
        .uplink_ready    (uplink_ready),
        .fifo_full       (fifo_full),
        .fifo_level      (fifo_level),
        .busy            (busy)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [75:0] ft [N_BUSES];

    task automatic cmp(input string nm, input logic [80:0] act, input logic [80:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycles since grant, a queue of entries, and the held head.
    bit          m_live = 0;
    bit          m_busy;
    int          m_phase;
    logic [4:0]  m_sel;
    int          m_last;
    logic [80:0] m_q[$];
    logic [80:0] m_hold;
    logic [80:0] m_head;
    bit          m_pop, m_push;
    logic [80:0] m_pe;
    bit          m_found;
    int          m_idx;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_phase = 0; m_sel = '0; m_last = N_BUSES - 1;
            m_q.delete(); m_hold = '0;
        end else begin
            m_pop  = (m_q.size() != 0) && uplink_ready;
            m_push = m_busy && (m_phase == RD_LAT + 1);
            m_pe   = {m_sel, ft[m_sel]};
            if (m_busy) begin
                if (m_phase == RD_LAT + 1) begin
                    m_busy = 0;
                    m_last = int'(m_sel);
                end else begin
                    m_phase++;
                end
            end else if (enable && irq != 0 && m_q.size() < DEPTH) begin
                m_found = 0;
                for (int i = 1; i <= N_BUSES; i++) begin
                    m_idx = (m_last + i) % N_BUSES;
                    if (!m_found && irq[m_idx]) begin
                        m_sel = 5'(m_idx);
                        m_found = 1;
                    end
                end
                m_busy  = 1;
                m_phase = 0;
            end
            if (m_pop) m_hold = m_q.pop_front();
            if (m_push) m_q.push_back(m_pe);
        end
        m_live = 1;
        #1;
        if (m_live) begin
            m_head = (m_q.size() != 0) ? m_q[0] : m_hold;
            cmp("m_ack",   81'(can_rec_ack), 81'(m_busy && m_phase == RD_LAT + 1));
            cmp("m_busy",  81'(busy), 81'(m_busy));
            cmp("m_sel",   81'(can_rec_select), 81'(m_sel));
            cmp("m_level", 81'(fifo_level), 81'(m_q.size()));
            cmp("m_full",  81'(fifo_full), 81'(m_q.size() == DEPTH));
            cmp("m_valid", 81'(uplink_valid), 81'(m_q.size() != 0));
            cmp("m_head",  {uplink_bus_id, data_rec_uplink}, m_head);
        end
    end

    // Bus-side emulation: data settles RD_LAT cycles after select moves; ack clears irq.
    logic [4:0] prev_sel = '0;
    int         stable   = 0;
    int         ack_cnt  = 0;

    task automatic tick();
        @(negedge clk);
        if (can_rec_ack) begin
            irq[can_rec_select] = 1'b0;
            ack_cnt++;
        end
        if (can_rec_select != prev_sel) stable = 0;
        else if (stable < 15) stable++;
        prev_sel = can_rec_select;
        can_rec_data = (stable >= RD_LAT) ? ft[can_rec_select] : '1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ack(input int max_t, input string nm);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!can_rec_ack && t < max_t);
        checks++;
        if (!can_rec_ack) begin
            errors++;
            $display("FAIL %s ack timeout actual=0 expected=1 after %0d cycles", nm, t);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [4:0] got [3];
    bit         busy_seen;

    initial begin
        for (int i = 0; i < N_BUSES; i++) ft[i] = {12'(i), 64'h0123_4567_89AB_0000 + 64'(i)};
        ft[4] = 76'hA5;
        rst = 1'b1; enable = 1'b1; irq = '0; uplink_ready = 1'b0; can_rec_data = '0;

        // Reset state
        ticks(3);
        cmp("rst_sel",   81'(can_rec_select), 81'(0));
        cmp("rst_ack",   81'(can_rec_ack), 81'(0));
        cmp("rst_valid", 81'(uplink_valid), 81'(0));
        cmp("rst_level", 81'(fifo_level), 81'(0));
        cmp("rst_busy",  81'(busy), 81'(0));
        cmp("rst_data",  81'(data_rec_uplink), 81'(0));
        rst = 1'b0;
        tick();

        // Single request on bus 4
        irq = 32'h0000_0010;
        tick();
        cmp("single_sel", 81'(can_rec_select), 81'(4));
        cmp("single_busy", 81'(busy), 81'(1));
        ticks(2);
        cmp("single_noack", 81'(can_rec_ack), 81'(0));
        tick();
        cmp("single_ack", 81'(can_rec_ack), 81'(1));
        tick();
        cmp("single_valid", 81'(uplink_valid), 81'(1));
        cmp("single_level", 81'(fifo_level), 81'(1));
        cmp("single_head", {uplink_bus_id, data_rec_uplink}, {5'd4, 76'hA5});
        cmp("single_irq", 81'(irq), 81'(0));
        uplink_ready = 1'b1;
        tick();
        uplink_ready = 1'b0;
        cmp("pop_level", 81'(fifo_level), 81'(0));
        cmp("pop_hold", 81'(data_rec_uplink), 81'(76'hA5));

        // Round-robin 0, 5, 31 then 0 again
        do_reset();
        irq = 32'h8000_0021;
        uplink_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(20, "rr_wait");
            got[k] = can_rec_select;
        end
        cmp("rr_first",  81'(got[0]), 81'(0));
        cmp("rr_second", 81'(got[1]), 81'(5));
        cmp("rr_third",  81'(got[2]), 81'(31));
        irq[0] = 1'b1;
        wait_ack(20, "rr_again");
        cmp("rr_again", 81'(can_rec_select), 81'(0));
        tick();

        // FIFO full backpressure with ten requesters (buses 3..12)
        do_reset();
        uplink_ready = 1'b0;
        ack_cnt = 0;
        irq = 32'h0000_1FF8;
        ticks(60);
        cmp("full_acks",  81'(ack_cnt), 81'(8));
        cmp("full_level", 81'(fifo_level), 81'(8));
        cmp("full_flag",  81'(fifo_full), 81'(1));
        cmp("full_idle",  81'(busy), 81'(0));
        cmp("full_irq",   81'(irq), 81'(32'h0000_1800));
        uplink_ready = 1'b1;
        tick();
        uplink_ready = 1'b0;
        cmp("full_pop_level", 81'(fifo_level), 81'(7));
        cmp("full_pop_head",  81'(uplink_bus_id), 81'(4));
        wait_ack(20, "full_regrant");
        cmp("full_regrant", 81'(can_rec_select), 81'(11));
        tick();
        cmp("full_relevel", 81'(fifo_level), 81'(8));
        cmp("full_acks9",   81'(ack_cnt), 81'(9));

        // Simultaneous push and pop at level 3
        do_reset();
        uplink_ready = 1'b0;
        irq = 32'h0000_000E;
        ticks(20);
        cmp("pp_level3", 81'(fifo_level), 81'(3));
        irq[6] = 1'b1;
        wait_ack(20, "pp_ack");
        uplink_ready = 1'b1;
        tick();
        uplink_ready = 1'b0;
        cmp("pp_level", 81'(fifo_level), 81'(3));
        cmp("pp_head",  {uplink_bus_id, data_rec_uplink}, {5'd2, ft[2]});

        // Enable dropped during WAIT
        do_reset();
        uplink_ready = 1'b1;
        irq = 32'h0000_0280;
        tick();
        cmp("en_sel", 81'(can_rec_select), 81'(7));
        tick();
        enable = 1'b0;
        wait_ack(10, "en_ack");
        cmp("en_ack_bus", 81'(can_rec_select), 81'(7));
        irq[2] = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy) busy_seen = 1;
        end
        cmp("en_nogrant", 81'(busy_seen), 81'(0));
        cmp("en_irq", 81'(irq), 81'(32'h0000_0204));
        enable = 1'b1;
        wait_ack(20, "en_next");
        cmp("en_next", 81'(can_rec_select), 81'(9));
        wait_ack(20, "en_next2");
        cmp("en_next2", 81'(can_rec_select), 81'(2));

        // Reset during WAIT
        do_reset();
        uplink_ready = 1'b0;
        irq = 32'h0000_1000;
        tick();
        cmp("rm_sel", 81'(can_rec_select), 81'(12));
        tick();
        rst = 1'b1;
        tick();
        cmp("rm_ack",   81'(can_rec_ack), 81'(0));
        cmp("rm_level", 81'(fifo_level), 81'(0));
        cmp("rm_valid", 81'(uplink_valid), 81'(0));
        cmp("rm_sel0",  81'(can_rec_select), 81'(0));
        cmp("rm_busy",  81'(busy), 81'(0));
        rst = 1'b0;
        irq[0] = 1'b1;
        wait_ack(20, "rm_prio");
        cmp("rm_prio", 81'(can_rec_select), 81'(0));
        ticks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mopshub_uplink_collector.md
Name: mopshub_uplink_collector

Overview:
- Upstream feeder of the MOPSHUB uplink path.
- Watches the per-bus CAN receive interrupts of all 32 buses and selects one bus at a time by round-robin.
- Captures each selected bus's 76-bit received frame into an 8-deep first-word-fall-through FIFO, tagged with the bus ID.
- Presents frames to the elink/uplink encoder with a valid/ready handshake; this output is what drives data_rec_uplink and can_rec_select at top level.

Parameters:
- N_BUSES, 32, number of CAN buses; bus IDs 0..N_BUSES-1.
- FRAME_W, 76, width of one CAN frame word.
- FIFO_DEPTH, 8, uplink FIFO entries; must be a power of 2.
- RD_LAT, 2, cycles from can_rec_select change to can_rec_data being stable.

Ports:
- clk  in  1  system clock (40 MHz domain).
- rst  in  1  synchronous reset, active-high.
- enable  in  1  when 0, no new bus is granted; an in-flight capture still completes.
- irq_can_rec  in  N_BUSES  level request per bus; held high until acked.
- can_rec_data  in  FRAME_W  frame from the currently selected bus.
- can_rec_select  out  5  bus currently granted for read.
- can_rec_ack  out  1  one-cycle pulse; clears irq of bus can_rec_select.
- data_rec_uplink  out  FRAME_W  FIFO head frame.
- uplink_bus_id  out  5  bus ID of the FIFO head frame.
- uplink_valid  out  1  FIFO head is valid.
- uplink_ready  in  1  consumer accepts the head when valid and ready are both high.
- fifo_full  out  1  FIFO count equals FIFO_DEPTH.
- fifo_level  out  4  FIFO occupancy, 0..FIFO_DEPTH.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - FSM goes to IDLE; FIFO is emptied; read and write pointers are 0.
  - Round-robin pointer last_served = N_BUSES-1, so bus 0 has first priority.
  - All outputs go to 0: can_rec_select=0, can_rec_ack=0, data_rec_uplink=0, uplink_bus_id=0, uplink_valid=0, fifo_full=0, fifo_level=0, busy=0.
  - Reset asserted mid-transaction aborts it with no ack and no FIFO write.
- FSM states are IDLE, SELECT, WAIT, CAPTURE.
- IDLE:
  - Leave IDLE only if enable=1, irq_can_rec≠0 and fifo_full=0.
  - Winner is the first set irq bit searching upward from last_served+1, wrapping modulo N_BUSES.
  - On leaving, register can_rec_select=winner and go to SELECT.
- SELECT: one cycle; load the wait counter with RD_LAT-1; go to WAIT.
- WAIT: count down; at 0 go to CAPTURE. Total latency from grant to capture edge is RD_LAT+1 cycles.
- CAPTURE:
  - Write {can_rec_select, can_rec_data} into the FIFO.
  - Pulse can_rec_ack for exactly this cycle.
  - Set last_served=can_rec_select; go to IDLE.
  - Minimum spacing between grants is RD_LAT+3 cycles.
- If the granted bus's irq drops before CAPTURE (spurious request), the frame is still captured and acked.
- can_rec_select holds its value after CAPTURE until the next grant.
- FIFO:
  - First-word-fall-through: data_rec_uplink and uplink_bus_id always show the head entry, and uplink_valid = (level≠0).
  - A pop occurs when uplink_valid && uplink_ready.
  - A simultaneous push and pop leaves the level unchanged.
  - A pop while empty is ignored.
  - Overflow cannot occur: a grant requires !fifo_full, and at most one capture is in flight.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; level is computed from a separate counter.
  - When empty, data outputs hold the last popped value; the consumer must qualify with uplink_valid.
- enable deasserted in SELECT, WAIT or CAPTURE: the transaction completes, then the FSM stays in IDLE.
- busy = (state≠IDLE).

Decomposition:
- Shared package mopshub_uplink_pkg holds:
  - a state enum with IDLE, SELECT, WAIT, CAPTURE;
  - constants BUS_ID_W=5 and FRAME_W=76;
  - a typedef uplink_entry_t = {bus_id[4:0], frame[75:0]}.
- One natural sub-module, uplink_sync_fifo: a parameterized synchronous FWFT FIFO (width, depth) with push, pop, full, level.
- The round-robin search stays as a function in the top module.

Test Plan:
- Single request: after reset, irq_can_rec=0x0000_0010, can_rec_data=76'hA5 → can_rec_select=4 one cycle after grant, can_rec_ack pulses 3 cycles later, FIFO head = {4, 76'hA5}, uplink_valid=1, fifo_level=1.
- Round-robin: irq bits 0, 5 and 31 held high, each bit cleared on its ack → grants occur in order 0, 5, 31, then 0 again when bit 0 is re-raised; no bus is granted twice while another is pending.
- FIFO full backpressure: uplink_ready=0 with 10 buses requesting → exactly 8 captures, fifo_full=1, FSM stays in IDLE; raising uplink_ready for 1 cycle → one pop, level goes to 7, one further grant follows.
- Simultaneous push/pop: level=3, capture cycle coincides with uplink_ready=1 → level stays 3, head advances to the next entry in order.
- enable drop mid-op: deassert enable in WAIT → capture and ack still occur, then no new grant while irq bits remain set; re-enable → the next grant follows the round-robin order.
- Reset mid-op: rst=1 during WAIT → no ack, level=0, uplink_valid=0, can_rec_select=0; after release, bus 0 has first priority.
